// File: rtl/mem_bank_arb_pkg.sv
// Shared types and helpers for mem_bank_arbiter: power-state encoding,
// response latency and the round-robin first-one search.
package mem_bank_arb_pkg;

    typedef enum logic [1:0] {
        PWR_ON     = 2'd0,
        PWR_GATING = 2'd1,
        PWR_OFF    = 2'd2,
        PWR_WAKING = 2'd3
    } pwr_state_e;

    localparam int RespLatency = 1;
    localparam int MaxReq      = 32;

    // Index of the first set bit of req at or after ptr, wrapping modulo n; -1 when none.
    function automatic int rr_first_one(input logic [MaxReq-1:0] req,
                                        input int ptr,
                                        input int n);
        int idx;
        int sel;
        sel = -1;
        for (int i = 0; i < MaxReq; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((i < n) && (sel < 0) && req[idx[4:0]]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_bank_pwr_fsm.sv
// Idle counter and power-gate handshake sequencer for the shared SRAM bank.
// awake_o is high only in ON; grants are suppressed in every other state.
module mem_bank_pwr_fsm
    import mem_bank_arb_pkg::*;
#(
    parameter int IdleCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_any_i,
    input  logic rvalid_any_i,
    input  logic pwrgate_ack_ni,
    output logic awake_o,
    output logic pwrgate_no
);

    localparam int CntW = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;

    pwr_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            awake_q;
    logic            pwrgate_q;

    // Power state, idle counter and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= PWR_ON;
            cnt_q     <= '0;
            awake_q   <= 1'b1;
            pwrgate_q <= 1'b1;
        end else begin
            case (state_q)
                PWR_ON: begin
                    if (req_any_i || rvalid_any_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CntW'(IdleCycles - 1)) begin
                        cnt_q     <= '0;
                        state_q   <= PWR_GATING;
                        awake_q   <= 1'b0;
                        pwrgate_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                // A request seen here must wait for OFF before waking.
                PWR_GATING: begin
                    if (!pwrgate_ack_ni) begin
                        state_q <= PWR_OFF;
                    end else begin
                        state_q <= PWR_GATING;
                    end
                end
                PWR_OFF: begin
                    if (req_any_i) begin
                        state_q   <= PWR_WAKING;
                        pwrgate_q <= 1'b1;
                    end else begin
                        state_q <= PWR_OFF;
                    end
                end
                PWR_WAKING: begin
                    if (pwrgate_ack_ni) begin
                        state_q <= PWR_ON;
                        awake_q <= 1'b1;
                    end else begin
                        state_q <= PWR_WAKING;
                    end
                end
                default: begin
                    state_q   <= PWR_ON;
                    cnt_q     <= '0;
                    awake_q   <= 1'b1;
                    pwrgate_q <= 1'b1;
                end
            endcase
        end
    end

    assign awake_o    = awake_q;
    assign pwrgate_no = pwrgate_q;

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank among NumReq requesters.
// Define MEM_BANK_ARB_PWRGATE_EN to build the idle power-gate sequencer.
module mem_bank_arbiter
    import mem_bank_arb_pkg::*;
#(
    parameter int NumReq     = 2,
    parameter int NumWords   = 1024,
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int IdleCycles = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*4-1:0]           be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [3:0]                    mem_be_o,
    input  logic [DataWidth-1:0]          mem_rdata_i,
    output logic                          pwrgate_no,
    input  logic                          pwrgate_ack_ni
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrW-1:0]   rr_ptr_q;
    logic [PtrW-1:0]   rr_ptr_d;
    logic [NumReq-1:0] gnt_s;
    logic [NumReq-1:0] rsp_pipe_q [RespLatency];
    logic              awake_s;
    int                sel_s;

`ifdef MEM_BANK_ARB_PWRGATE_EN
    mem_bank_pwr_fsm #(
        .IdleCycles (IdleCycles)
    ) u_pwr_fsm (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_any_i      (|req_i),
        .rvalid_any_i   (|rvalid_o),
        .pwrgate_ack_ni (pwrgate_ack_ni),
        .awake_o        (awake_s),
        .pwrgate_no     (pwrgate_no)
    );
`else
    logic unused_pwr_s;
    assign unused_pwr_s = pwrgate_ack_ni | (IdleCycles < 1);
    assign awake_s      = 1'b1;
    assign pwrgate_no   = 1'b1;
`endif

    // Round-robin grant search and next pointer.
    always_comb begin
        gnt_s    = '0;
        rr_ptr_d = rr_ptr_q;
        sel_s    = rr_first_one(MaxReq'(req_i), int'(rr_ptr_q), NumReq);
        for (int k = 0; k < NumReq; k++) begin
            gnt_s[k] = awake_s && (sel_s == k);
        end
        if (|gnt_s) begin
            rr_ptr_d = (sel_s == NumReq - 1) ? '0 : PtrW'(sel_s + 1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // AND-OR mux of the granted requester's payload; all zero without a grant.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int k = 0; k < NumReq; k++) begin
            mem_we_o    = mem_we_o    | (we_i[k] & gnt_s[k]);
            mem_addr_o  = mem_addr_o  | (addr_i[k*AddrWidth +: AddrWidth] & {AddrWidth{gnt_s[k]}});
            mem_wdata_o = mem_wdata_o | (wdata_i[k*DataWidth +: DataWidth] & {DataWidth{gnt_s[k]}});
            mem_be_o    = mem_be_o    | (be_i[k*4 +: 4] & {4{gnt_s[k]}});
        end
    end

    // Pointer and response-valid pipeline matching the bank's read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                rsp_pipe_q[i] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            rsp_pipe_q[0] <= gnt_s;
            for (int i = 1; i < RespLatency; i++) begin
                rsp_pipe_q[i] <= rsp_pipe_q[i-1];
            end
        end
    end

    assign gnt_o     = gnt_s;
    assign mem_req_o = |gnt_s;
    assign rvalid_o  = rsp_pipe_q[RespLatency-1];
    assign rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter with a behavioural 1-cycle SRAM and a response scoreboard.
// Power-gating steps are compiled when MEM_BANK_ARB_PWRGATE_EN is defined.
module tb_mem_bank_arbiter;

    localparam int NumReq = 2;
    localparam int AW     = 10;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [2*AW-1:0]   addr_i;
    logic [63:0]       wdata_i;
    logic [7:0]        be_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_rdata_i;
    logic              pwrgate_no;
    logic              pwrgate_ack_ni;

    logic [AW-1:0]     addr0, addr1;
    logic [31:0]       wd0, wd1;
    logic [3:0]        be0, be1;
    logic [31:0]       sram [1024];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]  rv;
        logic [31:0] data;
        logic        chk;
    } rsp_t;
    rsp_t sb_q[$];

    assign addr_i  = {addr1, addr0};
    assign wdata_i = {wd1, wd0};
    assign be_i    = {be1, be0};

    always #5 clk_i = ~clk_i;

    mem_bank_arbiter #(
        .NumReq     (NumReq),
        .NumWords   (1024),
        .DataWidth  (32),
        .IdleCycles (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .we_i           (we_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .be_i           (be_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_rdata_i    (mem_rdata_i),
        .pwrgate_no     (pwrgate_no),
        .pwrgate_ack_ni (pwrgate_ack_ni)
    );

    // Behavioural single-port SRAM with byte enables and one-cycle read latency.
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check the combinational grant side, then check the response.
    task automatic step(input logic [1:0] req, input logic [1:0] we, input logic [1:0] exp_gnt,
                        input logic [31:0] exp_data, input logic chk_data, input string tag);
        rsp_t          e;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic [3:0]    eb;
        req_i = req;
        we_i  = we;
        #1;
        ewe = 1'b0; ea = '0; ed = '0; eb = '0;
        if (exp_gnt[0]) begin
            ewe = we[0]; ea = addr0; ed = wd0; eb = be0;
        end else if (exp_gnt[1]) begin
            ewe = we[1]; ea = addr1; ed = wd1; eb = be1;
        end
        chk({tag, " gnt"}, 32'(gnt_o), 32'(exp_gnt));
        chk({tag, " mem_req"}, 32'(mem_req_o), 32'(|exp_gnt));
        chk({tag, " mem_we"}, 32'(mem_we_o), 32'(ewe));
        chk({tag, " mem_addr"}, 32'(mem_addr_o), 32'(ea));
        chk({tag, " mem_wdata"}, mem_wdata_o, ed);
        chk({tag, " mem_be"}, 32'(mem_be_o), 32'(eb));
        sb_q.push_back('{rv: exp_gnt, data: exp_data, chk: chk_data});
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        chk({tag, " rvalid"}, 32'(rvalid_o), 32'(e.rv));
        if (e.chk) chk({tag, " rdata"}, rdata_o, e.data);
    endtask

    initial begin
        rst_ni = 1'b0; req_i = '0; we_i = '0; pwrgate_ack_ni = 1'b1;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; be0 = '0; be1 = '0;
        repeat (2) @(negedge clk_i);
        chk("reset rvalid", 32'(rvalid_o), 32'h0);
        chk("reset gnt", 32'(gnt_o), 32'h0);
        chk("reset mem_req", 32'(mem_req_o), 32'h0);
        chk("reset pwrgate", 32'(pwrgate_no), 32'h1);
        rst_ni = 1'b1;

        // Basic write then read by requester 0.
        addr0 = 10'h010; wd0 = 32'hDEADBEEF; be0 = 4'hF;
        step(2'b01, 2'b01, 2'b01, 32'h0, 1'b0, "wr0");
        step(2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "rd0");

        // Requester 1 full write brings the pointer back to 0.
        addr1 = 10'h020; wd1 = 32'hAABBCCDD; be1 = 4'hF;
        step(2'b10, 2'b10, 2'b10, 32'h0, 1'b0, "wr1");

        // Rotation with both requesters reading.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(2'b11, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "rot0");
            else            step(2'b11, 2'b00, 2'b10, 32'hAABBCCDD, 1'b1, "rot1");
        end

        // Partial write on the low half-word.
        wd1 = 32'h11223344; be1 = 4'h3;
        step(2'b10, 2'b10, 2'b10, 32'h0, 1'b0, "pwr1");
        step(2'b10, 2'b00, 2'b10, 32'hAABB3344, 1'b1, "prd1");

        // Reset in the cycle after a grant; pointer must restart at 0.
        step(2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "pre_rst");
        req_i  = 2'b00;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst rvalid", 32'(rvalid_o), 32'h0);
        chk("mid_rst pwrgate", 32'(pwrgate_no), 32'h1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(2'b11, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "post_rst");

`ifdef MEM_BANK_ARB_PWRGATE_EN
        // Five idle steps: first still sees rvalid, then four counted.
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "idle");
        chk("pd before", 32'(pwrgate_no), 32'h1);
        step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "idle4");
        chk("pd gating", 32'(pwrgate_no), 32'h0);
        step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "gating");
        pwrgate_ack_ni = 1'b0;
        step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "to_off");
        chk("pd off", 32'(pwrgate_no), 32'h0);
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "off_req");
        chk("wake rise", 32'(pwrgate_no), 32'h1);
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "waking1");
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "waking2");
        pwrgate_ack_ni = 1'b1;
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "waking_ack");
        step(2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "first_on");

        // Race: request in the threshold cycle wins.
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "idle_r");
        step(2'b10, 2'b00, 2'b10, 32'hAABB3344, 1'b1, "race");
        chk("race no gating", 32'(pwrgate_no), 32'h1);

        // Request arriving during GATING completes the power-down, then wakes.
        for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "idle_g");
        chk("gating2", 32'(pwrgate_no), 32'h0);
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "gating_req");
        pwrgate_ack_ni = 1'b0;
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "gating_ack");
        chk("off2", 32'(pwrgate_no), 32'h0);
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "off2_req");
        chk("wake2", 32'(pwrgate_no), 32'h1);
        pwrgate_ack_ni = 1'b1;
        step(2'b01, 2'b00, 2'b00, 32'h0, 1'b0, "waking2_ack");
        step(2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "served2");
`else
        // Without power gating, idling and ack toggles never gate the bank.
        for (int i = 0; i < 6; i++) begin
            pwrgate_ack_ni = i[0];
            step(2'b00, 2'b00, 2'b00, 32'h0, 1'b0, "idle");
            chk("no gating", 32'(pwrgate_no), 32'h1);
        end
        pwrgate_ack_ni = 1'b1;
        step(2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1, "after_idle");
`endif

        req_i = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
